// File: rtl/syn_ram_pkg.sv
// Shared types and constants for the syn_ram arbiter slice.
package syn_ram_pkg;

  localparam int SYN_RAM_ADDR_W = 4;
  localparam int SYN_RAM_DATA_W = 2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_DATA = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant picker; define SYN_RAM_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 wins ties) instead of round-robin.
module rr_arb2
  import syn_ram_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

`ifdef SYN_RAM_ARB_FIXED_PRIO_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // One-hot grant; a tie goes to the requester that did not win last time
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef SYN_RAM_ARB_FIXED_PRIO_EN
      2'b11:   grant = 2'b01;
`else
      2'b11: begin
        if (last_grant == REQ1) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
`endif
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/syn_ram.sv
// 16x2 synchronous single-port RAM: registered read, output gated by oe.
module syn_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              oe,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];
  logic [DATA_W-1:0] q_r;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= din;
    end
  end

  // Read register captures the addressed word on non-write cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {DATA_W{1'b0}};
    end else if (!we) begin
      q_r <= mem_r[addr];
    end
  end

  assign dout = oe ? q_r : {DATA_W{1'b0}};

endmodule

// File: rtl/syn_ram_arbiter.sv
// Two-requester arbiter/sequencer serialising reads and writes onto syn_ram.
// Tie policy selectable with SYN_RAM_ARB_FIXED_PRIO_EN (see rr_arb2).
module syn_ram_arbiter
  import syn_ram_pkg::*;
#(
  parameter int ADDR_W = SYN_RAM_ADDR_W,
  parameter int DATA_W = SYN_RAM_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                busy,
  output logic                ram_rst,
  output logic                ram_we,
  output logic                ram_oe,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout
);

  arb_state_e        state_r, next_state_s;
  logic              last_grant_r, owner_r, we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r, rsp_rdata_r;
  logic [1:0]        rsp_valid_r, grant_s;
  logic              win_s, win_we_s, start_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  assign win_s       = grant_s[1];
  assign win_we_s    = req_we[win_s];
  assign win_addr_s  = win_s ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign win_wdata_s = win_s ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  assign start_s     = (state_r == IDLE) && (grant_s != 2'b00);

  assign ram_rst   = rst;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;

  // Next-state and RAM pin decode; RAM pins follow state so reset drops them at once
  always_comb begin
    next_state_s = state_r;
    req_ready    = 2'b00;
    busy         = 1'b1;
    ram_we       = 1'b0;
    ram_oe       = 1'b0;
    ram_addr     = {ADDR_W{1'b0}};
    ram_din      = {DATA_W{1'b0}};
    case (state_r)
      IDLE: begin
        busy      = 1'b0;
        req_ready = grant_s;
        if (grant_s != 2'b00) begin
          next_state_s = win_we_s ? WR : RD;
        end else begin
          next_state_s = IDLE;
        end
      end
      WR: begin
        ram_we       = 1'b1;
        ram_addr     = addr_r;
        ram_din      = wdata_r;
        next_state_s = IDLE;
      end
      RD: begin
        ram_addr     = addr_r;
        next_state_s = RD_DATA;
      end
      RD_DATA: begin
        ram_oe       = 1'b1;
        ram_addr     = addr_r;
        next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, latched request fields and the read response register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= REQ1;
      owner_r      <= REQ0;
      we_r         <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      rsp_valid_r  <= 2'b00;
      rsp_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      state_r     <= next_state_s;
      rsp_valid_r <= 2'b00;
      if (start_s) begin
        owner_r      <= win_s;
        we_r         <= win_we_s;
        addr_r       <= win_addr_s;
        wdata_r      <= win_wdata_s;
        last_grant_r <= win_s;
      end
      if (state_r == RD_DATA) begin
        rsp_rdata_r <= ram_dout;
        rsp_valid_r <= (owner_r == REQ1) ? 2'b10 : 2'b01;
      end
    end
  end

endmodule
